tl_vc_sched: RTL

TL_VC_SCHED -- requirements
Module: tl_vc_sched

---
 rtl/tl_vc_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tl_vc_sched.sv
// rtl/tl_vc_sched.sv - transport-layer VC scheduler locking the eligible buffer with most credits per packet
// Define TL_VC_SCHED_RR_EN for rotating tie-break among buffers with equal credits.
module tl_vc_sched #(
  parameter int NUM_REQ     = 12,
  parameter int CREDIT_BITS = 4,
  parameter int MIN_CREDITS = 2,
  parameter int MAX_BEATS   = 15,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(MAX_BEATS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_tvalid,
  input  logic                                 in_tlast,
  output logic                                 in_tready,
  input  logic [NUM_REQ-1:0][CREDIT_BITS-1:0]  g_credits,
  input  logic [NUM_REQ-1:0]                   b_full,
  output logic [NUM_REQ-1:0]                   b_wr_en,
  output logic [PW-1:0]                        sel_ptr,
  output logic                                 sel_vld,
  output logic [BW-1:0]                        beat_cnt,
  output logic                                 pkt_done,
  output logic                                 pkt_ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic [CREDIT_BITS-1:0] MIN_C = CREDIT_BITS'(MIN_CREDITS);
  localparam logic [BW-1:0]          MAX_B = BW'(MAX_BEATS);

`ifdef TL_VC_SCHED_RR_EN
  localparam int            CW    = PW + 1;
  localparam logic [CW-1:0] NUM_W = CW'(NUM_REQ);
  logic [PW-1:0] rot_q, rot_d;
`else
  localparam int CW = PW;
`endif

  state_e                   state_q, state_d;
  logic [PW-1:0]            sel_ptr_q, sel_ptr_d;
  logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
  logic                     pkt_done_q, pkt_done_d;
  logic                     pkt_ovf_q, pkt_ovf_d;
  logic [NUM_REQ-1:0]       elig;
  logic                     pick_vld;
  logic [PW-1:0]            pick_idx;
  logic [CREDIT_BITS-1:0]   pick_cred;
  logic [BW-1:0]            beat_inc;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = (g_credits[i] >= MIN_C) && !b_full[i];
    end
  end

  // Strict '>' keeps the first candidate in scan order, so the scan start decides ties.
  always_comb begin : p_pick
    logic [CW-1:0] cand;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_cred = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = CW'(k);
`ifdef TL_VC_SCHED_RR_EN
      cand = cand + {1'b0, rot_q};
      if (cand >= NUM_W) cand = cand - NUM_W;
`endif
      if (elig[cand[PW-1:0]] && (!pick_vld || (g_credits[cand[PW-1:0]] > pick_cred))) begin
        pick_vld  = 1'b1;
        pick_idx  = cand[PW-1:0];
        pick_cred = g_credits[cand[PW-1:0]];
      end
    end
  end

  assign beat_inc = (beat_cnt_q == MAX_B) ? MAX_B : beat_cnt_q + BW'(1);

  always_comb begin
    state_d    = state_q;
    sel_ptr_d  = sel_ptr_q;
    beat_cnt_d = beat_cnt_q;
    pkt_done_d = 1'b0;
    pkt_ovf_d  = 1'b0;
    in_tready  = 1'b0;
    b_wr_en    = '0;
`ifdef TL_VC_SCHED_RR_EN
    rot_d      = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_tvalid && pick_vld) begin
          state_d    = XFER;
          sel_ptr_d  = pick_idx;
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        in_tready = !b_full[sel_ptr_q];
        if (in_tvalid && in_tready) begin
          b_wr_en[sel_ptr_q] = 1'b1;
          beat_cnt_d         = beat_inc;
          // in_tlast wins when it coincides with the beat limit.
          if (in_tlast || (beat_inc == MAX_B)) begin
            state_d    = IDLE;
            pkt_done_d = in_tlast;
            pkt_ovf_d  = !in_tlast;
`ifdef TL_VC_SCHED_RR_EN
            rot_d      = (sel_ptr_q == PW'(NUM_REQ - 1)) ? '0 : sel_ptr_q + PW'(1);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_ptr_q  <= '0;
      beat_cnt_q <= '0;
      pkt_done_q <= 1'b0;
      pkt_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_ptr_q  <= sel_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_done_q <= pkt_done_d;
      pkt_ovf_q  <= pkt_ovf_d;
    end
  end

`ifdef TL_VC_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_q <= '0;
    end else begin
      rot_q <= rot_d;
    end
  end
`endif

  assign sel_ptr  = sel_ptr_q;
  assign sel_vld  = (state_q == XFER);
  assign beat_cnt = beat_cnt_q;
  assign pkt_done = pkt_done_q;
  assign pkt_ovf  = pkt_ovf_q;

endmodule
